// File: rtl/ad7960_pkg.sv
// rtl/ad7960_pkg.sv - shared state encoding, widths and helpers for the AD7960 acquisition sequencer
package ad7960_pkg;

    typedef logic [4:0] state_t;

    localparam state_t ST_IDLE   = 5'b00001;
    localparam state_t ST_SETTLE = 5'b00010;
    localparam state_t ST_RUN    = 5'b00100;
    localparam state_t ST_GUARD  = 5'b01000;
    localparam state_t ST_DRAIN  = 5'b10000;

    localparam int MAX_AVG_LOG2 = 4;
    localparam int ADC_DATA_W   = 18;
    localparam int ACC_W        = ADC_DATA_W + MAX_AVG_LOG2;

    localparam logic [3:0] EN_OFF = 4'b0000;

    function automatic logic [2:0] clamp_k(input logic [2:0] k);
        return (k > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : k;
    endfunction

endpackage

// File: rtl/ad7960_avg_acc.sv
// rtl/ad7960_avg_acc.sv - 2^k sample accumulator with arithmetic-shift result and strobe
module ad7960_avg_acc
    import ad7960_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int AW     = ACC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic [2:0]        k_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] result_o,
    output logic              strobe_o
);

    logic [AW-1:0] acc_q, acc_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [AW-1:0] sum;
    logic [4:0]    target;
    logic          last;

    // The result is formed from the sum including the current sample, so it
    // is available in the same cycle as the final adc_rdy_i.
    always_comb begin
        sum      = acc_q + {{(AW-DATA_W){sample_i[DATA_W-1]}}, sample_i};
        target   = 5'd1 << k_i;
        last     = ((cnt_q + 5'd1) == target);
        strobe_o = add_i && last;
        result_o = DATA_W'($signed(sum) >>> k_i);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ad7960_acq_sequencer.sv
// rtl/ad7960_acq_sequencer.sv - burst acquisition FSM, averaged result register and overrun tracking
module ad7960_acq_sequencer
    import ad7960_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 64,
    parameter int GUARD_CYC  = 40
) (
    input  logic              fast_clk_i,
    input  logic              buffer_reset_s,
    input  logic [3:0]        cfg_en_i,
    input  logic [2:0]        cfg_avg_log2_i,
    input  logic [CNT_W-1:0]  cfg_num_i,
    input  logic              arm_i,
    input  logic              abort_i,
    output logic              adc_start_o,
    output logic [3:0]        adc_en_o,
    input  logic              adc_rdy_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
);

    localparam int TMAX = (SETTLE_CYC > GUARD_CYC) ? SETTLE_CYC : GUARD_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              cont_q, cont_d;
    logic [3:0]        en_q, en_d;
    logic [2:0]        k_q, k_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              overrun_q, overrun_d;
    logic              done_q, done_d;

    logic              acc_clear;
    logic              acc_add;
    logic              acc_strobe;
    logic [DATA_W-1:0] acc_result;

    // Abort takes priority over a coincident sample so a partial average never escapes.
    assign acc_add   = (state_q == ST_RUN) && adc_rdy_i && !abort_i;
    assign acc_clear = ((state_q == ST_IDLE) && arm_i) ||
                       (((state_q == ST_SETTLE) || (state_q == ST_RUN)) && abort_i);

    ad7960_avg_acc #(
        .DATA_W (DATA_W),
        .AW     (DATA_W + MAX_AVG_LOG2)
    ) u_avg_acc (
        .clk_i    (fast_clk_i),
        .rst_i    (buffer_reset_s),
        .clear_i  (acc_clear),
        .add_i    (acc_add),
        .k_i      (k_q),
        .sample_i (adc_data_i),
        .result_o (acc_result),
        .strobe_o (acc_strobe)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rem_d       = rem_q;
        cont_d      = cont_q;
        en_d        = en_q;
        k_d         = k_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        overrun_d   = overrun_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    en_d      = cfg_en_i;
                    k_d       = clamp_k(cfg_avg_log2_i);
                    rem_d     = cfg_num_i;
                    cont_d    = (cfg_num_i == '0);
                    overrun_d = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    timer_d = '0;
                    state_d = ST_GUARD;
                end else if (timer_q == TW'(SETTLE_CYC - 1)) begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    timer_d = '0;
                    state_d = ST_GUARD;
                end else if (acc_strobe && !cont_q) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        timer_d = '0;
                        state_d = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (timer_q == TW'(GUARD_CYC - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (!res_valid_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A dropped result still counts toward the burst length above.
        if (acc_strobe) begin
            if (!res_valid_q || res_ready_i) begin
                res_valid_d = 1'b1;
                res_data_d  = acc_result;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (res_valid_q && res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge fast_clk_i or posedge buffer_reset_s) begin
        if (buffer_reset_s) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            rem_q       <= '0;
            cont_q      <= 1'b0;
            en_q        <= EN_OFF;
            k_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rem_q       <= rem_d;
            cont_q      <= cont_d;
            en_q        <= en_d;
            k_q         <= k_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

    assign adc_start_o = (state_q == ST_RUN);
    assign adc_en_o    = (state_q == ST_IDLE) ? EN_OFF : en_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign done_o      = done_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_ad7960_acq_sequencer.sv
// tb/tb_ad7960_acq_sequencer.sv - directed self-checking bench for ad7960_acq_sequencer
module tb_ad7960_acq_sequencer;

    localparam int S = 8;
    localparam int G = 6;

    logic        fast_clk_i = 1'b0;
    logic        buffer_reset_s;
    logic [3:0]  cfg_en_i;
    logic [2:0]  cfg_avg_log2_i;
    logic [15:0] cfg_num_i;
    logic        arm_i;
    logic        abort_i;
    logic        adc_start_o;
    logic [3:0]  adc_en_o;
    logic        adc_rdy_i;
    logic [17:0] adc_data_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [17:0] res_data_o;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;

    int compared   = 0;
    int mismatched = 0;

    ad7960_acq_sequencer #(
        .DATA_W     (18),
        .CNT_W      (16),
        .SETTLE_CYC (S),
        .GUARD_CYC  (G)
    ) dut (
        .fast_clk_i     (fast_clk_i),
        .buffer_reset_s (buffer_reset_s),
        .cfg_en_i       (cfg_en_i),
        .cfg_avg_log2_i (cfg_avg_log2_i),
        .cfg_num_i      (cfg_num_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .adc_start_o    (adc_start_o),
        .adc_en_o       (adc_en_o),
        .adc_rdy_i      (adc_rdy_i),
        .adc_data_i     (adc_data_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_data_o     (res_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overrun_o      (overrun_o)
    );

    always #5 fast_clk_i = ~fast_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk_i);
        #1;
    endtask

    task automatic arm(input logic [3:0] en, input logic [2:0] k, input logic [15:0] num);
        cfg_en_i       = en;
        cfg_avg_log2_i = k;
        cfg_num_i      = num;
        arm_i          = 1'b1;
        tick();
        arm_i          = 1'b0;
    endtask

    task automatic sample(input logic [17:0] v);
        adc_rdy_i  = 1'b1;
        adc_data_i = v;
        tick();
        adc_rdy_i  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (done_o !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        buffer_reset_s = 1'b1;
        cfg_en_i = '0; cfg_avg_log2_i = '0; cfg_num_i = '0;
        arm_i = 1'b0; abort_i = 1'b0; adc_rdy_i = 1'b0; adc_data_i = '0;
        res_ready_i = 1'b1;
        tick(); tick();
        buffer_reset_s = 1'b0;
        tick();
        chk("rst_busy",    {31'd0, busy_o},      32'd0);
        chk("rst_start",   {31'd0, adc_start_o}, 32'd0);
        chk("rst_en",      {28'd0, adc_en_o},    32'd0);
        chk("rst_valid",   {31'd0, res_valid_o}, 32'd0);
        chk("rst_data",    {14'd0, res_data_o},  32'd0);
        chk("rst_done",    {31'd0, done_o},      32'd0);
        chk("rst_overrun", {31'd0, overrun_o},   32'd0);

        // k=0, num=3, ready high
        arm(4'hA, 3'd0, 16'd3);
        chk("t1_busy",  {31'd0, busy_o},   32'd1);
        chk("t1_en",    {28'd0, adc_en_o}, 32'hA);
        repeat (S) tick();
        chk("t1_start", {31'd0, adc_start_o}, 32'd1);
        sample(18'h00005);
        chk("t1_v0",    {31'd0, res_valid_o}, 32'd1);
        chk("t1_d0",    {14'd0, res_data_o},  32'h00005);
        sample(18'h3FFF9);
        chk("t1_d1",    {14'd0, res_data_o},  32'h3FFF9);
        sample(18'h1FFFF);
        chk("t1_d2",    {14'd0, res_data_o},  32'h1FFFF);
        chk("t1_stop",  {31'd0, adc_start_o}, 32'd0);
        repeat (G) tick();
        chk("t1_nodone", {31'd0, done_o},     32'd0);
        chk("t1_drain",  {31'd0, busy_o},     32'd1);
        chk("t1_vlow",   {31'd0, res_valid_o}, 32'd0);
        tick();
        chk("t1_done",   {31'd0, done_o},     32'd1);
        chk("t1_idle",   {31'd0, busy_o},     32'd0);
        chk("t1_en_off", {28'd0, adc_en_o},   32'd0);
        chk("t1_ovr",    {31'd0, overrun_o},  32'd0);
        tick();
        chk("t1_pulse",  {31'd0, done_o},     32'd0);

        // k=2, num=1, with an ignored arm during SETTLE
        arm(4'h5, 3'd2, 16'd1);
        chk("t2_en", {28'd0, adc_en_o}, 32'h5);
        cfg_en_i = 4'h3; cfg_num_i = 16'd5; arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("t2_en_kept", {28'd0, adc_en_o}, 32'h5);
        repeat (S - 2) tick();
        chk("t2_start_lo", {31'd0, adc_start_o}, 32'd0);
        tick();
        chk("t2_start_hi", {31'd0, adc_start_o}, 32'd1);
        sample(18'h00004);
        sample(18'h00004);
        sample(18'h3FFFC);
        chk("t2_partial", {31'd0, res_valid_o}, 32'd0);
        sample(18'h3FFF8);
        chk("t2_valid", {31'd0, res_valid_o}, 32'd1);
        chk("t2_data",  {14'd0, res_data_o},  32'h3FFFF);
        chk("t2_stop",  {31'd0, adc_start_o}, 32'd0);
        wait_done("t2_done", G + 5);
        tick();

        // k=7 clamps to 4: 16 samples 0,2,..,30 average to 15
        arm(4'h1, 3'd7, 16'd1);
        repeat (S) tick();
        for (int i = 0; i < 15; i++) sample(18'(2 * i));
        chk("t3_no_early", {31'd0, res_valid_o}, 32'd0);
        sample(18'd30);
        chk("t3_valid", {31'd0, res_valid_o}, 32'd1);
        chk("t3_data",  {14'd0, res_data_o},  32'd15);
        wait_done("t3_done", G + 5);
        tick();

        // k=0, num=4, downstream stalled
        res_ready_i = 1'b0;
        arm(4'h2, 3'd0, 16'd4);
        repeat (S) tick();
        sample(18'd11);
        sample(18'd22);
        sample(18'd33);
        sample(18'd44);
        chk("t4_held",  {14'd0, res_data_o},  32'd11);
        chk("t4_ovr",   {31'd0, overrun_o},   32'd1);
        chk("t4_stop",  {31'd0, adc_start_o}, 32'd0);
        repeat (G + 10) tick();
        chk("t4_stuck", {31'd0, busy_o}, 32'd1);
        chk("t4_nodone", {31'd0, done_o}, 32'd0);
        res_ready_i = 1'b1;
        tick();
        chk("t4_vlow", {31'd0, res_valid_o}, 32'd0);
        tick();
        chk("t4_done", {31'd0, done_o}, 32'd1);
        tick();

        // continuous, abort coincident with a sample
        arm(4'h6, 3'd1, 16'd0);
        chk("t5_ovr_clr", {31'd0, overrun_o}, 32'd0);
        repeat (S) tick();
        sample(18'd100);
        chk("t5_partial", {31'd0, res_valid_o}, 32'd0);
        adc_rdy_i = 1'b1; adc_data_i = 18'd200; abort_i = 1'b1;
        tick();
        adc_rdy_i = 1'b0; abort_i = 1'b0;
        chk("t5_noresult", {31'd0, res_valid_o}, 32'd0);
        chk("t5_stop",     {31'd0, adc_start_o}, 32'd0);
        chk("t5_busy",     {31'd0, busy_o},      32'd1);
        sample(18'd300);
        chk("t5_guard_ign", {31'd0, res_valid_o}, 32'd0);
        wait_done("t5_done", G + 5);
        tick();

        // asynchronous reset in RUN with a held result
        res_ready_i = 1'b0;
        arm(4'h3, 3'd0, 16'd0);
        repeat (S) tick();
        sample(18'd9);
        chk("t6_valid", {31'd0, res_valid_o}, 32'd1);
        chk("t6_run",   {31'd0, adc_start_o}, 32'd1);
        #1;
        buffer_reset_s = 1'b1;
        #1;
        chk("t6_start", {31'd0, adc_start_o}, 32'd0);
        chk("t6_en",    {28'd0, adc_en_o},    32'd0);
        chk("t6_busy",  {31'd0, busy_o},      32'd0);
        chk("t6_vld",   {31'd0, res_valid_o}, 32'd0);
        chk("t6_data",  {14'd0, res_data_o},  32'd0);
        tick();
        buffer_reset_s = 1'b0;
        tick();
        chk("t6_idle",  {31'd0, busy_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
